// File: rtl/reaction_round_ctrl.sv
// reaction_round_ctrl
// Sequencer for one reaction-timer round: IDLE -> WAIT (random delay) ->
// REACT (counting ms) -> DONE / FOUL / TIMEOUT.
// - Conditions the raw active-low push buttons into single-cycle press events.
// - Keeps the best (minimum) valid reaction time seen since reset.
// - Every output comes from a register; there is no combinational path
//   from KEY to any output.

module reaction_round_ctrl #(
    parameter int MIN_DELAY_MS = 1024,
    parameter int MAX_REACT_MS = 9999,
    parameter int CNT_W        = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       KEY,
    input  logic             tick,
    input  logic [9:0]       lfsr_val,
    output logic [2:0]       state,
    output logic             wait_en,
    output logic             go_led,
    output logic [CNT_W-1:0] reaction_ms,
    output logic [CNT_W-1:0] best_ms,
    output logic             best_valid,
    output logic             result_valid,
    output logic             false_start
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_REACT   = 3'd2,
        ST_DONE    = 3'd3,
        ST_FOUL    = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_t;

    localparam logic [11:0]      MIN_DELAY       = 12'(MIN_DELAY_MS);
    localparam logic [CNT_W-1:0] MAX_REACT       = CNT_W'(MAX_REACT_MS);
    localparam logic [CNT_W-1:0] LAST_BEFORE_MAX = CNT_W'(MAX_REACT_MS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO        = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE         = CNT_W'(1);

    // A finished reaction time becomes the new best when there is no best
    // yet or it is strictly faster; a tie keeps the earlier record.
    function automatic logic beats_best(input logic             have_best,
                                        input logic [CNT_W-1:0] cand,
                                        input logic [CNT_W-1:0] best);
        return (!have_best) || (cand < best);
    endfunction

    // Key conditioning registers: 2-flop synchronizer, previous-sample
    // register, and an arm bit that blocks presses until the key has been
    // seen released with real (post-reset) samples in the synchronizer.
    logic [1:0]  key_meta_r;
    logic [1:0]  key_sync_r;
    logic [1:0]  key_prev_r;
    logic [1:0]  key_arm_r;
    logic [1:0]  fill_r;
    logic [1:0]  press_s;
    logic        start_press_s;
    logic        react_press_s;

    // FSM and output registers
    state_t           state_r;
    logic [11:0]      delay_cnt_r;
    logic             wait_en_r;
    logic             go_led_r;
    logic [CNT_W-1:0] reaction_r;
    logic [CNT_W-1:0] best_r;
    logic             best_valid_r;
    logic             result_valid_r;
    logic             false_start_r;
    logic [11:0]      delay_load_s;

    // Falling edge of the synchronized key, qualified by the arm bit.
    assign press_s       = key_arm_r & key_prev_r & ~key_sync_r;
    assign start_press_s = press_s[0];
    assign react_press_s = press_s[1];

    // Random wait length: zero-extended LFSR value plus the fixed minimum.
    assign delay_load_s  = {2'b00, lfsr_val} + MIN_DELAY;

    // Synchronize the buttons and arm each key once it reads released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_meta_r <= 2'b11;
            key_sync_r <= 2'b11;
            key_prev_r <= 2'b11;
            key_arm_r  <= 2'b00;
            fill_r     <= 2'd0;
        end else begin
            key_meta_r <= KEY;
            key_sync_r <= key_meta_r;
            key_prev_r <= key_sync_r;
            if (fill_r != 2'd2) begin
                fill_r <= fill_r + 2'd1;
            end else begin
                fill_r <= fill_r;
            end
            // key_sync_r only holds a real key sample once fill_r reaches 2.
            if (fill_r == 2'd2) begin
                key_arm_r <= key_arm_r | key_sync_r;
            end else begin
                key_arm_r <= key_arm_r;
            end
        end
    end

    // Round sequencer with registered status outputs and best-time tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            delay_cnt_r    <= 12'd0;
            wait_en_r      <= 1'b0;
            go_led_r       <= 1'b0;
            reaction_r     <= CNT_ZERO;
            best_r         <= CNT_ZERO;
            best_valid_r   <= 1'b0;
            result_valid_r <= 1'b0;
            false_start_r  <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_FOUL, ST_TIMEOUT: begin
                    // React presses and ticks are ignored while idle or
                    // showing a result; only start begins a new round.
                    if (start_press_s) begin
                        state_r       <= ST_WAIT;
                        delay_cnt_r   <= delay_load_s;
                        reaction_r    <= CNT_ZERO;
                        wait_en_r     <= 1'b1;
                        go_led_r      <= 1'b0;
                        false_start_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // A react press beats a same-cycle delay expiry.
                    if (react_press_s) begin
                        state_r       <= ST_FOUL;
                        wait_en_r     <= 1'b0;
                        false_start_r <= 1'b1;
                        reaction_r    <= CNT_ZERO;
                    end else if (tick) begin
                        if (delay_cnt_r == 12'd0) begin
                            state_r    <= ST_REACT;
                            wait_en_r  <= 1'b0;
                            go_led_r   <= 1'b1;
                            reaction_r <= CNT_ZERO;
                        end else begin
                            delay_cnt_r <= delay_cnt_r - 12'd1;
                        end
                    end
                end
                ST_REACT: begin
                    // The press freezes the count; a same-cycle tick is dropped.
                    if (react_press_s) begin
                        state_r        <= ST_DONE;
                        go_led_r       <= 1'b0;
                        result_valid_r <= 1'b1;
                        if (beats_best(best_valid_r, reaction_r, best_r)) begin
                            best_r       <= reaction_r;
                            best_valid_r <= 1'b1;
                        end
                    end else if (tick) begin
                        if (reaction_r == LAST_BEFORE_MAX) begin
                            state_r    <= ST_TIMEOUT;
                            go_led_r   <= 1'b0;
                            reaction_r <= MAX_REACT;
                        end else begin
                            reaction_r <= reaction_r + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    wait_en_r     <= 1'b0;
                    go_led_r      <= 1'b0;
                    false_start_r <= 1'b0;
                    reaction_r    <= CNT_ZERO;
                end
            endcase
        end
    end

    assign state        = state_r;
    assign wait_en      = wait_en_r;
    assign go_led       = go_led_r;
    assign reaction_ms  = reaction_r;
    assign best_ms      = best_r;
    assign best_valid   = best_valid_r;
    assign result_valid = result_valid_r;
    assign false_start  = false_start_r;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl: a linear sequence of rounds with
// hand-computed expectations checked by immediate assertions.

module tb_reaction_round_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  KEY;
    logic        tick;
    logic [9:0]  lfsr_val;
    logic [2:0]  state;
    logic        wait_en;
    logic        go_led;
    logic [13:0] reaction_ms;
    logic [13:0] best_ms;
    logic        best_valid;
    logic        result_valid;
    logic        false_start;

    int n_cmp = 0;
    int n_err = 0;

    reaction_round_ctrl #(
        .MIN_DELAY_MS(1024),
        .MAX_REACT_MS(9999),
        .CNT_W(14)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .KEY(KEY),
        .tick(tick),
        .lfsr_val(lfsr_val),
        .state(state),
        .wait_en(wait_en),
        .go_led(go_led),
        .reaction_ms(reaction_ms),
        .best_ms(best_ms),
        .best_valid(best_valid),
        .result_valid(result_valid),
        .false_start(false_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive tick for exactly this edge, sample 1 ns after it.
    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    // n tick pulses, each one clock wide, separated by one idle clock.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1);
            cyc(1'b0);
        end
    endtask

    // Press key b; the FSM acts on the third edge, which optionally carries a tick.
    task automatic press(input int b, input logic with_tick);
        KEY[b] = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        cyc(with_tick);
    endtask

    task automatic release_keys();
        KEY = 2'b11;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
    endtask

    // Start a round and run the wait phase of n ticks into REACT.
    task automatic start_round(input int n);
        press(0, 1'b0);
        release_keys();
        ticks(n);
    endtask

    initial begin
        rst_n    = 1'b0;
        KEY      = 2'b11;
        tick     = 1'b0;
        lfsr_val = 10'd5;
        cyc(1'b0);
        cyc(1'b0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_best_valid", 32'(best_valid), 32'd0);
        rst_n = 1'b1;

        // Idle with keys released: nothing moves.
        ticks(100);
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_reaction", 32'(reaction_ms), 32'd0);
        chk("idle_best_valid", 32'(best_valid), 32'd0);
        chk("idle_status", 32'({wait_en, go_led, result_valid, false_start}), 32'd0);

        // Round A: delay 1029, start press mid-wait ignored, react at 237.
        press(0, 1'b0);
        chk("a_wait_state", 32'(state), 32'd1);
        chk("a_wait_en", 32'(wait_en), 32'd1);
        release_keys();
        ticks(500);
        press(0, 1'b0);
        chk("a_start_ignored", 32'(state), 32'd1);
        release_keys();
        ticks(529);
        chk("a_still_wait", 32'(state), 32'd1);
        ticks(1);
        chk("a_react_state", 32'(state), 32'd2);
        chk("a_go_led", 32'(go_led), 32'd1);
        chk("a_react_zero", 32'(reaction_ms), 32'd0);
        chk("a_wait_en_off", 32'(wait_en), 32'd0);
        ticks(237);
        chk("a_running", 32'(reaction_ms), 32'd237);
        press(1, 1'b0);
        chk("a_done_state", 32'(state), 32'd3);
        chk("a_done_reaction", 32'(reaction_ms), 32'd237);
        chk("a_result_valid", 32'(result_valid), 32'd1);
        chk("a_best", 32'(best_ms), 32'd237);
        chk("a_best_valid", 32'(best_valid), 32'd1);
        cyc(1'b0);
        chk("a_result_pulse_end", 32'(result_valid), 32'd0);
        release_keys();
        ticks(3);
        press(1, 1'b0);
        chk("a_done_hold_state", 32'(state), 32'd3);
        chk("a_done_hold_reaction", 32'(reaction_ms), 32'd237);
        release_keys();

        // Round B: slower result (300) does not replace the best.
        start_round(1030);
        chk("b_react_state", 32'(state), 32'd2);
        ticks(300);
        press(1, 1'b0);
        chk("b_reaction", 32'(reaction_ms), 32'd300);
        chk("b_best_kept", 32'(best_ms), 32'd237);
        release_keys();

        // Round C: longest delay (2047) and a faster result (150).
        lfsr_val = 10'd1023;
        press(0, 1'b0);
        release_keys();
        ticks(2047);
        chk("c_still_wait", 32'(state), 32'd1);
        ticks(1);
        chk("c_react_state", 32'(state), 32'd2);
        ticks(150);
        press(1, 1'b0);
        chk("c_reaction", 32'(reaction_ms), 32'd150);
        chk("c_best_new", 32'(best_ms), 32'd150);
        release_keys();
        lfsr_val = 10'd5;

        // Early false start.
        press(0, 1'b0);
        release_keys();
        ticks(10);
        press(1, 1'b0);
        chk("f1_state", 32'(state), 32'd4);
        chk("f1_false_start", 32'(false_start), 32'd1);
        chk("f1_reaction", 32'(reaction_ms), 32'd0);
        chk("f1_best", 32'(best_ms), 32'd150);
        chk("f1_wait_en", 32'(wait_en), 32'd0);
        release_keys();

        // Restart from FOUL, then false start on the expiring tick.
        press(0, 1'b0);
        chk("f2_restart_state", 32'(state), 32'd1);
        chk("f2_restart_fs", 32'(false_start), 32'd0);
        chk("f2_restart_wait_en", 32'(wait_en), 32'd1);
        release_keys();
        ticks(1029);
        chk("f2_still_wait", 32'(state), 32'd1);
        press(1, 1'b1);
        chk("f2_state", 32'(state), 32'd4);
        chk("f2_go_led", 32'(go_led), 32'd0);
        chk("f2_best", 32'(best_ms), 32'd150);
        release_keys();

        // Timeout: 9999 ticks with no press.
        start_round(1030);
        ticks(9998);
        chk("t_before_state", 32'(state), 32'd2);
        chk("t_before_reaction", 32'(reaction_ms), 32'd9998);
        ticks(1);
        chk("t_state", 32'(state), 32'd5);
        chk("t_reaction", 32'(reaction_ms), 32'd9999);
        chk("t_go_led", 32'(go_led), 32'd0);
        chk("t_result_valid", 32'(result_valid), 32'd0);
        chk("t_best", 32'(best_ms), 32'd150);
        ticks(3);
        press(1, 1'b0);
        chk("t_hold_state", 32'(state), 32'd5);
        chk("t_hold_reaction", 32'(reaction_ms), 32'd9999);
        release_keys();

        // Press on the same cycle as the 9999th tick: press wins.
        start_round(1030);
        ticks(9998);
        press(1, 1'b1);
        chk("tp_state", 32'(state), 32'd3);
        chk("tp_reaction", 32'(reaction_ms), 32'd9998);
        chk("tp_result_valid", 32'(result_valid), 32'd1);
        chk("tp_best", 32'(best_ms), 32'd150);
        release_keys();

        // Reset mid-REACT with start held low through reset.
        start_round(1030);
        ticks(10);
        chk("r_go_led_before", 32'(go_led), 32'd1);
        rst_n = 1'b0;
        KEY   = 2'b10;
        cyc(1'b0);
        rst_n = 1'b1;
        chk("r_state", 32'(state), 32'd0);
        chk("r_best", 32'(best_ms), 32'd0);
        chk("r_best_valid", 32'(best_valid), 32'd0);
        chk("r_go_led", 32'(go_led), 32'd0);
        chk("r_reaction", 32'(reaction_ms), 32'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0);
        end
        chk("r_held_no_press", 32'(state), 32'd0);
        release_keys();
        press(0, 1'b0);
        chk("r_repress_state", 32'(state), 32'd1);
        release_keys();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
